// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Issue-side controller for the execute-stage ALU. It takes one operation per
// request from decode, drives the ALU operand/opcode/shift/cycle-count inputs
// from registers, and captures the ALU result and flags into a held status word.
// A one-cycle done pulse marks each completion.
//
// Optional feature macro: ALU_SEQ_ACCUM_EN
//   defined   : ACCUMBYTES runs over ACCUM_STEPS ALU cycles. Each cycle's result
//               is fed back as the next A operand.
//   undefined : the ACC state does not exist. ACCUMBYTES is issued like any
//               single-cycle op, so the result holds only the stage-0 partial sums.
module alu_op_sequencer #(
  parameter int ACCUM_STEPS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        controlInSeqStart,
  input  logic        controlInSeqFlush,
  input  logic [4:0]  controlInSeqOp,
  input  logic [1:0]  controlInSeqShiftDir,
  input  logic        controlInSeqSetFlags,
  input  logic [39:0] dataInSeqA,
  input  logic [39:0] dataInSeqB,
  output logic [39:0] dataOutSeqAluA,
  output logic [39:0] dataOutSeqAluB,
  output logic [4:0]  controlOutSeqAluOp,
  output logic [1:0]  controlOutSeqAluShiftDir,
  output logic [2:0]  controlOutSeqAluCycleCnt,
  input  logic [39:0] dataInSeqAluResult,
  input  logic        controlInSeqAluZ,
  input  logic        controlInSeqAluC,
  input  logic        controlInSeqAluV,
  input  logic        controlInSeqAluN,
  output logic [39:0] dataOutSeqResult,
  output logic [3:0]  controlOutSeqFlags,
  output logic        controlOutSeqBusy,
  output logic        controlOutSeqDone
);

  // Opcode shared with the decode stage's opcode table
  localparam logic [4:0] OpAccumBytes = 5'h0C;
  // Cycle-count value on the final ACCUMBYTES step
  localparam logic [2:0] LastCnt = 3'(ACCUM_STEPS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
`ifdef ALU_SEQ_ACCUM_EN
    ACC   = 2'd2,
`endif
    DONE  = 2'd3
  } seqState_t;

  seqState_t state;
  seqState_t nextState;

  logic acceptReq;
  logic captureEn;
  logic accAdvance;
  logic setFlagsReg;

  // State register; reset abandons any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic. Flush beats everything, including a simultaneous start.
  always_comb begin
    nextState  = state;
    acceptReq  = 1'b0;
    captureEn  = 1'b0;
    accAdvance = 1'b0;
    case (state)
      IDLE, DONE: begin
        nextState = IDLE;
        if (!controlInSeqFlush && controlInSeqStart) begin
          acceptReq = 1'b1;
`ifdef ALU_SEQ_ACCUM_EN
          nextState = (controlInSeqOp == OpAccumBytes) ? ACC : ISSUE;
`else
          nextState = ISSUE;
`endif
        end
      end
      ISSUE: begin
        if (controlInSeqFlush) begin
          nextState = IDLE;
        end else begin
          captureEn = 1'b1;
          nextState = DONE;
        end
      end
`ifdef ALU_SEQ_ACCUM_EN
      ACC: begin
        if (controlInSeqFlush) begin
          nextState = IDLE;
        end else if (controlOutSeqAluCycleCnt == LastCnt) begin
          captureEn = 1'b1;
          nextState = DONE;
        end else begin
          accAdvance = 1'b1;
        end
      end
`endif
      default: nextState = IDLE;
    endcase
  end

  // ALU-facing registers: load on accept, feed back on each ACC step, else hold
  // (the cycle count drops back to zero whenever no ACC step follows)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dataOutSeqAluA           <= '0;
      dataOutSeqAluB           <= '0;
      controlOutSeqAluOp       <= '0;
      controlOutSeqAluShiftDir <= '0;
      controlOutSeqAluCycleCnt <= '0;
      setFlagsReg              <= 1'b0;
    end else if (acceptReq) begin
      dataOutSeqAluA           <= dataInSeqA;
      dataOutSeqAluB           <= dataInSeqB;
      controlOutSeqAluOp       <= controlInSeqOp;
      controlOutSeqAluShiftDir <= controlInSeqShiftDir;
      controlOutSeqAluCycleCnt <= '0;
      setFlagsReg              <= controlInSeqSetFlags;
    end else if (accAdvance && controlOutSeqAluCycleCnt != LastCnt) begin
      dataOutSeqAluA           <= dataInSeqAluResult;
      dataOutSeqAluB           <= '0;
      controlOutSeqAluCycleCnt <= controlOutSeqAluCycleCnt + 3'd1;
    end else begin
      controlOutSeqAluCycleCnt <= '0;
    end
  end

  // Status capture: the result always updates, but flags update only on request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dataOutSeqResult   <= '0;
      controlOutSeqFlags <= '0;
    end else if (captureEn) begin
      dataOutSeqResult <= dataInSeqAluResult;
      if (setFlagsReg) begin
        controlOutSeqFlags <= {controlInSeqAluN, controlInSeqAluZ,
                               controlInSeqAluC, controlInSeqAluV};
      end
    end
  end

  // Busy covers the cycles that drive the ALU, and done is the cycle after capture
  always_comb begin
    controlOutSeqBusy = (state == ISSUE)
`ifdef ALU_SEQ_ACCUM_EN
                        || (state == ACC)
`endif
                        ;
    controlOutSeqDone = (state == DONE);
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
// Directed bench for alu_op_sequencer. A small behavioural ALU answers the
// sequencer's ALU-facing outputs. Stimulus is applied on the falling clock edge,
// and outputs are sampled on that same edge before the next stimulus is applied.
module tb_alu_op_sequencer;

  localparam logic [4:0] OP_ADD = 5'h01;
  localparam logic [4:0] OP_SUB = 5'h02;
  localparam logic [4:0] OP_MOV = 5'h03;
  localparam logic [4:0] OP_ACC = 5'h0C;

  logic        clk;
  logic        rst;
  logic        start;
  logic        flush;
  logic [4:0]  op;
  logic [1:0]  dir;
  logic        setF;
  logic [39:0] inA;
  logic [39:0] inB;
  logic [39:0] aluA;
  logic [39:0] aluB;
  logic [4:0]  aluOp;
  logic [1:0]  aluDir;
  logic [2:0]  aluCnt;
  logic [39:0] aluRes;
  logic        aluZ, aluC, aluV, aluN;
  logic [39:0] result;
  logic [3:0]  flags;
  logic        busy;
  logic        done;

  int checks;
  int failures;
  int doneCount;
  int base;
  logic [39:0] expResult;

  alu_op_sequencer #(.ACCUM_STEPS(4)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .controlInSeqStart        (start),
    .controlInSeqFlush        (flush),
    .controlInSeqOp           (op),
    .controlInSeqShiftDir     (dir),
    .controlInSeqSetFlags     (setF),
    .dataInSeqA               (inA),
    .dataInSeqB               (inB),
    .dataOutSeqAluA           (aluA),
    .dataOutSeqAluB           (aluB),
    .controlOutSeqAluOp       (aluOp),
    .controlOutSeqAluShiftDir (aluDir),
    .controlOutSeqAluCycleCnt (aluCnt),
    .dataInSeqAluResult       (aluRes),
    .controlInSeqAluZ         (aluZ),
    .controlInSeqAluC         (aluC),
    .controlInSeqAluV         (aluV),
    .controlInSeqAluN         (aluN),
    .dataOutSeqResult         (result),
    .controlOutSeqFlags       (flags),
    .controlOutSeqBusy        (busy),
    .controlOutSeqDone        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU. In ACCUMBYTES stage 0 it adds A and B byte-wise. In stage k
  // it folds byte k into byte 0 and clears byte k.
  always_comb begin
    logic [40:0] sum;
    int k;
    aluRes = '0;
    aluC   = 1'b0;
    aluV   = 1'b0;
    sum    = '0;
    k      = int'(aluCnt);
    case (aluOp)
      OP_ADD: begin
        sum    = {1'b0, aluA} + {1'b0, aluB};
        aluRes = sum[39:0];
        aluC   = sum[40];
        aluV   = (aluA[39] == aluB[39]) && (aluRes[39] != aluA[39]);
      end
      OP_SUB: begin
        aluRes = aluA - aluB;
        aluC   = aluA < aluB;
        aluV   = (aluA[39] != aluB[39]) && (aluRes[39] != aluA[39]);
      end
      OP_MOV: aluRes = aluA;
      OP_ACC: begin
        if (k == 0) begin
          for (int i = 0; i < 5; i++) aluRes[8*i +: 8] = aluA[8*i +: 8] + aluB[8*i +: 8];
        end else begin
          aluRes = aluA;
          if (k < 5) begin
            aluRes[7:0]     = aluA[7:0] + aluA[8*k +: 8];
            aluRes[8*k +: 8] = 8'h00;
          end
        end
      end
      default: aluRes = '0;
    endcase
    aluZ = (aluRes == 40'h0);
    aluN = aluRes[39];
  end

  task automatic checkOutput(input string tag, input logic [39:0] observed, input logic [39:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance one clock and count done pulses seen on the falling edge
  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
    if (done) doneCount++;
  endtask

  // Present a request for one cycle. On return the bench sits in cycle T+1.
  task automatic applyStimulus(input logic [4:0] o, input logic [1:0] d, input logic sf,
                               input logic [39:0] a, input logic [39:0] b);
    start = 1'b1;
    op    = o;
    dir   = d;
    setF  = sf;
    inA   = a;
    inB   = b;
    stepCycle();
    start = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    doneCount = 0;
    rst   = 1'b1;
    start = 1'($urandom);
    flush = 1'($urandom);
    op    = 5'($urandom);
    dir   = 2'($urandom);
    setF  = 1'($urandom);
    inA   = 40'({$urandom, $urandom});
    inB   = 40'({$urandom, $urandom});
    repeat (3) stepCycle();
    checkOutput("rstAluA", aluA, 0);
    checkOutput("rstAluB", aluB, 0);
    checkOutput("rstAluOp", 40'(aluOp), 0);
    checkOutput("rstShiftDir", 40'(aluDir), 0);
    checkOutput("rstCycleCnt", 40'(aluCnt), 0);
    checkOutput("rstResult", result, 0);
    checkOutput("rstFlags", 40'(flags), 0);
    checkOutput("rstBusy", 40'(busy), 0);
    checkOutput("rstDone", 40'(done), 0);

    start = 1'b0;
    flush = 1'b0;
    rst   = 1'b0;
    base  = doneCount;
    repeat (10) stepCycle();
    checkOutput("idleNoDone", 40'(doneCount - base), 0);

    // ADD overflowing into the sign bit
    applyStimulus(OP_ADD, 2'd0, 1'b1, 40'h7F_FFFF_FFFF, 40'h1);
    checkOutput("addBusyT1", 40'(busy), 1);
    checkOutput("addAluA", aluA, 40'h7F_FFFF_FFFF);
    checkOutput("addAluB", aluB, 40'h1);
    checkOutput("addAluOp", 40'(aluOp), 40'(OP_ADD));
    checkOutput("addCnt", 40'(aluCnt), 0);
    checkOutput("addDoneT1", 40'(done), 0);
    stepCycle();
    checkOutput("addDoneT2", 40'(done), 1);
    checkOutput("addBusyT2", 40'(busy), 0);
    checkOutput("addResult", result, 40'h80_0000_0000);
    checkOutput("addFlags", 40'(flags), 40'(4'b1001));
    stepCycle();
    checkOutput("addDonePulse", 40'(done), 0);

    // SUB without flag update keeps the previous flags
    applyStimulus(OP_SUB, 2'd0, 1'b0, 40'd5, 40'd5);
    stepCycle();
    checkOutput("subDone", 40'(done), 1);
    checkOutput("subResult", result, 0);
    checkOutput("subFlagsHeld", 40'(flags), 40'(4'b1001));
    stepCycle();

    // MOV passes the shift direction through
    applyStimulus(OP_MOV, 2'b10, 1'b1, 40'h12_3456_789A, 40'h0);
    checkOutput("movShiftDir", 40'(aluDir), 40'(2'b10));
    stepCycle();
    checkOutput("movResult", result, 40'h12_3456_789A);
    checkOutput("movFlags", 40'(flags), 0);
    stepCycle();

    // ACCUMBYTES reduction
    applyStimulus(OP_ACC, 2'd0, 1'b1, 40'h00_0003_0201, 40'h00_0006_0504);
`ifdef ALU_SEQ_ACCUM_EN
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("accCnt%0d", k), 40'(aluCnt), 40'(k));
      checkOutput($sformatf("accBusy%0d", k), 40'(busy), 1);
      if (k == 0) checkOutput("accAluA0", aluA, 40'h00_0003_0201);
      if (k == 1) begin
        checkOutput("accAluA1", aluA, 40'h00_0009_0705);
        checkOutput("accAluB1", aluB, 0);
      end
      stepCycle();
    end
    checkOutput("accDone", 40'(done), 1);
    checkOutput("accResult", result, 40'd21);
    expResult = 40'd21;
`else
    checkOutput("accCnt0", 40'(aluCnt), 0);
    stepCycle();
    checkOutput("accDone", 40'(done), 1);
    checkOutput("accResult", result, 40'h00_0009_0705);
    expResult = 40'h00_0009_0705;
`endif
    checkOutput("accFlags", 40'(flags), 0);
    stepCycle();

    // Start while busy is ignored, and exactly one done follows
    base = doneCount;
    applyStimulus(OP_ADD, 2'd0, 1'b1, 40'd10, 40'd20);
    start = 1'b1;
    op    = OP_SUB;
    inA   = 40'd100;
    inB   = 40'd1;
    stepCycle();
    start = 1'b0;
    repeat (5) stepCycle();
    checkOutput("busyStartOneDone", 40'(doneCount - base), 1);
    checkOutput("busyStartResult", result, 40'd30);
    expResult = 40'd30;

    // Flush during ISSUE: no capture, no done
    base = doneCount;
    applyStimulus(OP_ADD, 2'd0, 1'b1, 40'hFF_FFFF_FFFF, 40'h1);
    flush = 1'b1;
    stepCycle();
    flush = 1'b0;
    checkOutput("flushIssueBusy", 40'(busy), 0);
    checkOutput("flushIssueDone", 40'(done), 0);
    checkOutput("flushIssueResult", result, expResult);
    checkOutput("flushIssueFlags", 40'(flags), 0);
    stepCycle();
    checkOutput("flushIssueNoDone", 40'(doneCount - base), 0);

`ifdef ALU_SEQ_ACCUM_EN
    // Start during ACC at T+2 is ignored
    base = doneCount;
    applyStimulus(OP_ACC, 2'd0, 1'b1, 40'h00_0003_0201, 40'h00_0006_0504);
    stepCycle();
    start = 1'b1;
    op    = OP_ADD;
    inA   = 40'd7;
    inB   = 40'd7;
    stepCycle();
    start = 1'b0;
    repeat (6) stepCycle();
    checkOutput("accStartOneDone", 40'(doneCount - base), 1);
    checkOutput("accStartResult", result, 40'd21);
    expResult = 40'd21;

    // Flush at T+3 of an ACCUMBYTES
    base = doneCount;
    applyStimulus(OP_ACC, 2'd0, 1'b1, 40'h1, 40'h1);
    stepCycle();
    stepCycle();
    flush = 1'b1;
    stepCycle();
    flush = 1'b0;
    checkOutput("accFlushBusy", 40'(busy), 0);
    checkOutput("accFlushDone", 40'(done), 0);
    repeat (3) stepCycle();
    checkOutput("accFlushNoDone", 40'(doneCount - base), 0);
    checkOutput("accFlushResult", result, expResult);
    checkOutput("accFlushFlags", 40'(flags), 0);
`endif

    // Start and flush together in IDLE is ignored
    base  = doneCount;
    start = 1'b1;
    flush = 1'b1;
    op    = OP_ADD;
    inA   = 40'd3;
    inB   = 40'd4;
    stepCycle();
    start = 1'b0;
    flush = 1'b0;
    checkOutput("startFlushBusy", 40'(busy), 0);
    repeat (2) stepCycle();
    checkOutput("startFlushNoDone", 40'(doneCount - base), 0);
    checkOutput("startFlushResult", result, expResult);

    // Start accepted in the DONE cycle
    applyStimulus(OP_ADD, 2'd0, 1'b1, 40'd2, 40'd3);
    stepCycle();
    checkOutput("chainDone1", 40'(done), 1);
    checkOutput("chainResult1", result, 40'd5);
    start = 1'b1;
    op    = OP_SUB;
    inA   = 40'd9;
    inB   = 40'd2;
    stepCycle();
    start = 1'b0;
    checkOutput("chainBusy", 40'(busy), 1);
    checkOutput("chainAluOp", 40'(aluOp), 40'(OP_SUB));
    checkOutput("chainAluA", aluA, 40'd9);
    stepCycle();
    checkOutput("chainDone2", 40'(done), 1);
    checkOutput("chainResult2", result, 40'd7);
    stepCycle();

    // Reset mid-operation clears everything immediately
    applyStimulus(OP_ADD, 2'd0, 1'b1, 40'h11, 40'h22);
    rst = 1'b1;
    #1;
    checkOutput("midRstBusy", 40'(busy), 0);
    checkOutput("midRstAluA", aluA, 0);
    checkOutput("midRstAluOp", 40'(aluOp), 0);
    checkOutput("midRstResult", result, 0);
    stepCycle();
    rst  = 1'b0;
    base = doneCount;
    repeat (4) stepCycle();
    checkOutput("midRstNoDone", 40'(doneCount - base), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Issue-side controller for the execute-stage ALU. Accepts one operation per request from decode, drives the ALU's operand, opcode, shift-direction and cycle-count inputs, and sequences the multi-cycle ACCUMBYTES reduction by feeding each ALU result back as the next operand. It captures the final result and the Z/C/V/N flags into a registered status word and reports completion with a one-cycle done pulse.

## Interface
Parameters:
- ACCUM_STEPS, 4, number of ALU cycles for ACCUMBYTES; cycle count runs 0..ACCUM_STEPS-1 and must be ≤ 8.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- controlInSeqStart  in  1  request strobe, sampled only when controlOutSeqBusy=0.
- controlInSeqFlush  in  1  abort current operation.
- controlInSeqOp  in  5  opcode, same encoding as opcodes.inc.
- controlInSeqShiftDir  in  2  shift direction for MOV.
- controlInSeqSetFlags  in  1  update status flags on completion.
- dataInSeqA / dataInSeqB  in  40  operands.
- dataOutSeqAluA / dataOutSeqAluB  out  40  to ALU operand inputs.
- controlOutSeqAluOp  out  5  to ALU opcode.
- controlOutSeqAluShiftDir  out  2  to ALU shift direction.
- controlOutSeqAluCycleCnt  out  3  to ALU cycle count.
- dataInSeqAluResult  in  40  from ALU result.
- controlInSeqAluZ, controlInSeqAluC, controlInSeqAluV, controlInSeqAluN  in  1 each  from ALU flags.
- dataOutSeqResult  out  40  last completed result, held.
- controlOutSeqFlags  out  4  {N,Z,C,V} status, held.
- controlOutSeqBusy  out  1  operation in flight.
- controlOutSeqDone  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, ISSUE, ACC, DONE. Reset → IDLE.
- IDLE/DONE with Start=1 and Flush=0: register op, shiftDir, setFlags, A, B.
  - Op ≠ ACCUMBYTES → ISSUE.
  - Op = ACCUMBYTES → ACC with count=0.
- ISSUE: drive registered operands, CycleCnt=0. Capture the ALU result and flags at the end of the cycle → DONE.
- ACC, count=0: drive registered A/B. Count k>0: AluA = the result captured in the previous cycle, AluB = 0. CycleCnt = k every cycle. At k=ACCUM_STEPS-1, capture the result and flags → DONE; otherwise k+1.
- DONE: Done=1 for exactly one cycle. Then → IDLE, or directly to ISSUE/ACC if a new Start is accepted in that cycle.
- Flags register updates only at the capture point and only if setFlags was registered as 1. dataOutSeqResult updates at every capture regardless of setFlags.
- Flush in any state: next state IDLE, no capture, no Done, result and flags unchanged. Flush wins over a simultaneous Start.
- Start while Busy=1 is ignored; no queuing.
- ALU-facing outputs hold their last driven values in IDLE, except CycleCnt, which returns to 0.
- Reset mid-operation: immediately abandon the operation. Every output goes to 0, the state goes to IDLE, and no Done is produced.

## Timing
- Reset value 0 on all outputs, including Result, Flags, Busy, Done, AluA/B, AluOp, ShiftDir and CycleCnt.
- Busy=1 during ISSUE and ACC only; Busy=0 in IDLE and DONE.
- Single-cycle op: Start accepted at cycle T, ALU driven in T+1, Done and valid Result/Flags in T+2. Back-to-back throughput is one op per 2 cycles.
- ACCUMBYTES: ALU driven in T+1..T+ACCUM_STEPS, Done in T+ACCUM_STEPS+1.
- All ALU-facing outputs are registered. The ALU's result is consumed combinationally in the same cycle it is driven.

## Configuration
- ALU_SEQ_ACCUM_EN defined: ACCUMBYTES is sequenced over ACCUM_STEPS cycles as above.
- Not defined: the ACC state is removed. ACCUMBYTES is issued as a single-cycle op with CycleCnt=0, and Done arrives at T+2 with the stage-0 partial sums.

## Test plan
- Reset with all inputs random: every output is 0 and the state is IDLE. Deassert reset, hold Start=0 for 10 cycles: no Done.
- ADD, A=40'h7F_FFFF_FFFF, B=1, SetFlags=1: at T+2, Done=1, Result=40'h80_0000_0000, Flags N=1,Z=0,C=0,V=1.
- SUB 5−5 with SetFlags=0, run after the ADD case: Result=0 at T+2, Flags unchanged from the previous case.
- ACCUMBYTES, A=40'h00_0003_0201, B=40'h00_0006_0504 (ALU_SEQ_ACCUM_EN defined): CycleCnt reads 0,1,2,3 in T+1..T+4; Done at T+5 with Result=21. Not defined: Done at T+2 with Result=40'h00_0009_0705.
- Start during an ACCUMBYTES at T+2: ignored, exactly one Done. Flush at T+3: no Done, Result and Flags unchanged, Busy=0 at T+4.
- Start and Flush both high in IDLE: ignored. Start asserted in the DONE cycle: accepted, Busy=1 in the next cycle.
